// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue: FSM state
// encoding, queue entry layout and the default reset vector.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_entry_t;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    // Instruction addresses are word aligned; the low two bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fifo.sv
// Circular buffer of fetched {pc, word} entries with push, pop and a flush
// that empties the buffer in one edge and takes priority over push/pop.
module instruction_fifo
    import fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  fetch_entry_t     push_entry_i,
    input  logic             pop_i,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A full buffer still takes a push when the head leaves on the same edge.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is only read behind a non-zero count, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch front end: keeps one memory request in flight and
// fills a small queue of {pc, word} entries for the datapath.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_request,
    output logic [31:0] imem_address,
    input  logic        imem_accept,
    input  logic        imem_valid,
    input  logic [31:0] imem_data,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        instruction_valid,
    input  logic        instruction_ready,
    output logic [31:0] instruction,
    output logic [31:0] program_counter
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e     state_q;
    fetch_state_e     state_d;
    logic [31:0]      fetch_ptr_q;
    logic [31:0]      fetch_ptr_d;
    logic [31:0]      req_pc_q;
    logic [31:0]      req_pc_d;
    logic             req_q;
    logic             req_d;

    logic             accept;
    logic             push;
    logic             pop;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             full;
    logic             empty;

    // The registered request is masked by redirect so a new fetch never
    // leaves in the same cycle as a flush.
    assign imem_request = req_q && !redirect;
    assign imem_address = fetch_ptr_q;
    assign accept       = imem_request && imem_accept;

    assign pop        = !empty && instruction_ready;
    assign push       = (state_q == BUSY) && imem_valid && !redirect;
    assign push_entry = '{pc: req_pc_q, word: imem_data};

    assign instruction_valid = !empty;
    assign instruction       = empty ? '0 : head.word;
    assign program_counter   = empty ? '0 : head.pc;

    instruction_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (clock),
        .rst_ni       (reset),
        .flush_i      (redirect),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_o       (head),
        .count_o      (count),
        .full_o       (full),
        .empty_o      (empty)
    );

    // Occupancy after this edge, used to decide whether a slot can be
    // reserved for the next request.
    always_comb begin
        count_next = count;
        if (redirect) begin
            count_next = '0;
        end else if (push && !pop && !full) begin
            count_next = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count - CNT_W'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        fetch_ptr_d = fetch_ptr_q;
        req_pc_d    = req_pc_q;

        if (redirect) begin
            fetch_ptr_d = word_align(redirect_target);
        end else if (accept) begin
            fetch_ptr_d = fetch_ptr_q + 32'd4;
            req_pc_d    = fetch_ptr_q;
        end

        // A response arriving with a redirect is consumed either way, so the
        // next state only depends on whether one is still owed.
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (imem_valid) begin
                    state_d = IDLE;
                end else if (redirect) begin
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                if (imem_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        req_d = (state_d == IDLE) && (count_next < CNT_W'(DEPTH));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            fetch_ptr_q <= RESET_VECTOR;
            req_pc_q    <= '0;
            req_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_ptr_q <= fetch_ptr_d;
            req_pc_q    <= req_pc_d;
            req_q       <= req_d;
        end
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of prefetch entries (power of two, 2..16).
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-003 clock  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 imem_request  output  1  fetch request valid.
REQ-006 imem_address  output  32  word-aligned fetch address.
REQ-007 imem_accept  input  1  memory accepts the request this cycle.
REQ-008 imem_valid  input  1  read data returned this cycle.
REQ-009 imem_data  input  32  returned instruction word.
REQ-010 redirect  input  1  taken branch/PC write; flush and refetch.
REQ-011 redirect_target  input  32  new fetch address; bits [1:0] SHALL be ignored (treated as 00).
REQ-012 instruction_valid  output  1  head entry available.
REQ-013 instruction_ready  input  1  datapath consumes head entry.
REQ-014 instruction  output  32  head instruction word.
REQ-015 program_counter  output  32  address of head instruction.

Function
REQ-016 SHALL keep a fetch pointer, incremented by 4 (modulo 2^32) on each accepted request; imem_address SHALL equal the fetch pointer.
REQ-017 At most one request SHALL be outstanding; FSM states IDLE, BUSY, DISCARD.
REQ-018 IDLE: imem_request=1 iff entries-in-queue < DEPTH and redirect=0; request and accept both high -> BUSY.
REQ-019 BUSY: imem_request=0; imem_valid -> write {pointer-of-request, imem_data} to queue tail, -> IDLE.
REQ-020 imem_request and imem_address SHALL stay stable while request is high and imem_accept is low, unless redirect.
REQ-021 Pop SHALL occur when instruction_valid and instruction_ready are both high; instruction_valid = queue not empty.
REQ-022 Push and pop in the same cycle SHALL leave the count unchanged, including when full.
REQ-023 Full queue: no request issued; a response for the one in-flight request always fits, because the request was only issued with a free slot reserved.
REQ-024 redirect SHALL, in the same edge, empty the queue (count=0), set fetch pointer to {redirect_target[31:2],2'b00}, and drop any simultaneous imem_valid data.
REQ-025 redirect in BUSY without imem_valid -> DISCARD; DISCARD drops the next imem_valid response, then -> IDLE.
REQ-026 redirect in BUSY with imem_valid in the same cycle -> IDLE (response discarded, nothing pending).
REQ-027 redirect in DISCARD SHALL stay in DISCARD and only update the fetch pointer.
REQ-028 A pop coinciding with redirect SHALL be treated as consumed; outputs are invalid from the next cycle.
REQ-029 First request after redirect SHALL go out no earlier than the cycle after redirect.
REQ-030 Minimum latency: response data visible on instruction the cycle after imem_valid.

Reset
REQ-031 Reset low SHALL asynchronously force: FSM IDLE, count 0, pointers 0, fetch pointer RESET_VECTOR.
REQ-032 Outputs during reset: imem_request=0, instruction_valid=0, instruction=0, program_counter=0, imem_address=RESET_VECTOR.
REQ-033 Release SHALL be handled synchronously; the first request is asserted the cycle after reset rises.
REQ-034 Reset mid-transaction SHALL abandon the outstanding request; the first post-reset imem_valid before any accept SHALL be ignored.

Structure
REQ-035 Shared package fetch_pkg SHALL hold the FSM state enum (IDLE/BUSY/DISCARD), the entry struct {pc[31:0], word[31:0]}, and the default reset vector constant.
REQ-036 Queue storage SHALL be a sub-module instruction_fifo (DEPTH-entry circular buffer, push/pop/flush, count, full/empty); FSM and fetch pointer live in fetch_queue.

Verification
REQ-037 Reset then imem_accept=1, one-cycle data 32'hE3A0_0001 -> imem_address 0, then 4; instruction=32'hE3A0_0001, program_counter=0.
REQ-038 instruction_ready=0, memory always ready -> exactly DEPTH(4) entries, then imem_request=0; one pop -> one new request at address 16.
REQ-039 redirect to 32'h0000_0103 while BUSY, response arrives 2 cycles later -> response dropped, next imem_address=32'h100, queue empty.
REQ-040 redirect with imem_valid in the same cycle -> data not enqueued, FSM IDLE, fetch at redirect target next cycle.
REQ-041 Full queue with simultaneous push and pop -> count stays 4, order preserved (program_counter 0,4,8,...).
REQ-042 Reset asserted in BUSY, stray imem_valid after release -> ignored; first fetch at RESET_VECTOR.
